// File: rtl/mem_load_store_ctrl.sv
// mem_load_store_ctrl: single-outstanding load/store controller that sits
// between the core datapath and the data-memory request/grant/response bus.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req_valid           core request strobe (sampled only when idle)
//   i_req_we              1 = store, 0 = load
//   i_req_size            00 byte, 01 half, 10 word, 11 illegal
//   i_req_addr            byte address
//   i_req_wdata           right-justified store data
//   o_busy                controller is not idle
//   o_done                one-cycle completion pulse
//   o_rdata_aligned       load data shifted down to bit 0, zero-filled
//   o_err_misalign        request was misaligned/illegal (with o_done)
//   o_err_timeout         bus did not answer in time (with o_done)
//   o_mem_req/we/addr     bus request, write enable, word address
//   o_mem_wdata/be        lane-replicated store data, byte enables
//   i_mem_gnt             bus grant
//   i_mem_rvalid/rdata    bus read response

module mem_load_store_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata_aligned,
    output logic        o_err_misalign,
    output logic        o_err_timeout,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [1:0]    r_off;

    logic          w_misalign;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic          w_expire;
    logic [31:0]   w_rdata_shift;

    // Lane placement of the incoming request, computed from the raw
    // request inputs so it can be registered straight onto the bus.
    always_comb begin
        w_be       = 4'b0000;
        w_wdata    = 32'h0;
        w_misalign = 1'b0;
        unique case (i_req_size)
            2'b00: begin
                w_wdata = {4{i_req_wdata[7:0]}};
                w_be    = 4'b0001 << i_req_addr[1:0];
            end
            2'b01: begin
                w_wdata    = {2{i_req_wdata[15:0]}};
                w_be       = 4'b0011 << i_req_addr[1:0];
                w_misalign = i_req_addr[0];
            end
            2'b10: begin
                w_wdata    = i_req_wdata;
                w_be       = 4'b1111;
                w_misalign = (i_req_addr[1:0] != 2'b00);
            end
            default: begin
                w_misalign = 1'b1;
            end
        endcase
    end

    // r_cnt holds the number of REQ/WAIT cycles already spent, so the
    // current cycle is the last one allowed when it equals TIMEOUT-1.
    assign w_expire      = (r_cnt == CNT_LAST);
    assign w_rdata_shift = i_mem_rdata >> {r_off, 3'b000};
    assign o_busy        = (r_state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_we            <= 1'b0;
            r_off           <= 2'b00;
            o_done          <= 1'b0;
            o_rdata_aligned <= 32'h0;
            o_err_misalign  <= 1'b0;
            o_err_timeout   <= 1'b0;
            o_mem_req       <= 1'b0;
            o_mem_we        <= 1'b0;
            o_mem_addr      <= 32'h0;
            o_mem_wdata     <= 32'h0;
            o_mem_be        <= 4'b0000;
        end else begin
            // Completion and error flags are single-cycle pulses.
            o_done         <= 1'b0;
            o_err_misalign <= 1'b0;
            o_err_timeout  <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_we  <= i_req_we;
                        r_off <= i_req_addr[1:0];
                        r_cnt <= '0;
                        if (w_misalign) begin
                            r_state        <= S_DONE;
                            o_done         <= 1'b1;
                            o_err_misalign <= 1'b1;
                        end else begin
                            r_state     <= S_REQ;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_req_we;
                            o_mem_addr  <= {i_req_addr[31:2], 2'b00};
                            o_mem_wdata <= i_req_we ? w_wdata : 32'h0;
                            o_mem_be    <= w_be;
                        end
                    end
                end

                S_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A grant on the final allowed cycle still counts.
                    if (i_mem_gnt || w_expire) begin
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_wdata <= 32'h0;
                        o_mem_be    <= 4'b0000;
                    end
                    if (i_mem_gnt) begin
                        if (r_we) begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_expire) begin
                        r_state       <= S_DONE;
                        o_done        <= 1'b1;
                        o_err_timeout <= 1'b1;
                    end
                end

                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_mem_rvalid) begin
                        o_rdata_aligned <= w_rdata_shift;
                        r_state         <= S_DONE;
                        o_done          <= 1'b1;
                    end else if (w_expire) begin
                        r_state       <= S_DONE;
                        o_done        <= 1'b1;
                        o_err_timeout <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
